// File: rtl/control_unit_if.sv
// Signal bundle between the microsequencer and its surroundings: start/opcode/flag
// inputs toward the sequencer and the control word / halt status coming back.
interface control_unit_if #(
    parameter int unsigned CW_WIDTH = 25,
    parameter int unsigned OP_WIDTH = 8
);
    logic                start;
    logic [OP_WIDTH-1:0] ir_in;
    logic                acc_neg;
    logic [CW_WIDTH-1:0] control;
    logic                halted;

    // Sequencer side: drives the control word bus
    modport master (
        input  start,
        input  ir_in,
        input  acc_neg,
        output control,
        output halted
    );

    // Datapath / environment side
    modport slave (
        output start,
        output ir_in,
        output acc_neg,
        input  control,
        input  halted
    );
endinterface

// File: rtl/control_unit.sv
// Moore microsequencer: fetch opcode, load IR, decode, fetch operand address,
// execute, repeat. The control word is registered together with the state.
module control_unit (
    input  logic          clk,
    input  logic          rst_n,
    control_unit_if.master bus
);
    localparam int unsigned CW_WIDTH = 25;
    localparam int unsigned OP_WIDTH = 8;

    // Control word bit positions
    localparam int unsigned C_PC_INC   = 0;
    localparam int unsigned C_PC_MBR   = 1;
    localparam int unsigned C_MAR_PC   = 2;
    localparam int unsigned C_MBR_MEM  = 3;
    localparam int unsigned C_MEM_MBR  = 4;
    localparam int unsigned C_MAR_MBR  = 5;
    localparam int unsigned C_BR_MBR   = 6;
    localparam int unsigned C_ACC_ADD  = 8;
    localparam int unsigned C_ACC_SUB  = 9;
    localparam int unsigned C_MBR_ACC  = 10;
    localparam int unsigned C_IR_MBR   = 11;
    localparam int unsigned C_ACC_AND  = 12;
    localparam int unsigned C_ACC_OR   = 13;
    localparam int unsigned C_ACC_NOT  = 14;
    localparam int unsigned C_ACC_SHL  = 15;
    localparam int unsigned C_ACC_SHR  = 16;
    localparam int unsigned C_ACC_BR   = 17;
    localparam int unsigned C_HALT     = 18;

    localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(8'h01);
    localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(8'h02);
    localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(8'h03);
    localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(8'h04);
    localparam logic [OP_WIDTH-1:0] OP_JMPGEZ = OP_WIDTH'(8'h05);
    localparam logic [OP_WIDTH-1:0] OP_JMP    = OP_WIDTH'(8'h06);
    localparam logic [OP_WIDTH-1:0] OP_HALT   = OP_WIDTH'(8'h07);
    localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(8'h08);
    localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(8'h09);
    localparam logic [OP_WIDTH-1:0] OP_NOT    = OP_WIDTH'(8'h0A);
    localparam logic [OP_WIDTH-1:0] OP_SHL    = OP_WIDTH'(8'h0B);
    localparam logic [OP_WIDTH-1:0] OP_SHR    = OP_WIDTH'(8'h0C);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC,
        S_OP0, S_OP1, S_OP2,
        S_EX0, S_EX1, S_EX2, S_EXU, S_HALT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [OP_WIDTH-1:0] op_q;
    logic [OP_WIDTH-1:0] op_sel;
    logic [CW_WIDTH-1:0] control;
    logic                halted;

    // Successor state; op is the live opcode in DEC and the latched one afterwards
    function automatic state_t next_state(input state_t s, input logic start,
                                          input logic [OP_WIDTH-1:0] op);
        state_t n;
        n = S_IDLE;
        case (s)
            S_IDLE: n = start ? S_F0 : S_IDLE;
            S_F0:   n = S_F1;
            S_F1:   n = S_F2;
            S_F2:   n = S_DEC;
            S_DEC: begin
                case (op)
                    OP_HALT:                  n = S_HALT;
                    OP_NOT, OP_SHL, OP_SHR:   n = S_EXU;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
                    OP_JMPGEZ, OP_JMP, OP_AND, OP_OR:
                                              n = S_OP0;
                    default:                  n = S_F0;
                endcase
            end
            S_OP0:  n = S_OP1;
            S_OP1:  n = S_OP2;
            S_OP2:  n = (op == OP_JMP || op == OP_JMPGEZ) ? S_F0 : S_EX0;
            S_EX0:  n = S_EX1;
            S_EX1:  n = (op == OP_STORE) ? S_F0 : S_EX2;
            S_EX2:  n = S_F0;
            S_EXU:  n = S_F0;
            S_HALT: n = S_HALT;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // Control word asserted while sitting in state s
    function automatic logic [CW_WIDTH-1:0] cw_for(input state_t s,
                                                   input logic [OP_WIDTH-1:0] op,
                                                   input logic neg);
        logic [CW_WIDTH-1:0] cw;
        cw = '0;
        case (s)
            S_F0, S_OP0: cw[C_MAR_PC] = 1'b1;
            S_F1, S_OP1: begin
                cw[C_MBR_MEM] = 1'b1;
                cw[C_PC_INC]  = 1'b1;
            end
            S_F2:  cw[C_IR_MBR] = 1'b1;
            S_OP2: begin
                if (op == OP_JMP)         cw[C_PC_MBR]  = 1'b1;
                else if (op == OP_JMPGEZ) cw[C_PC_MBR]  = ~neg;
                else                      cw[C_MAR_MBR] = 1'b1;
            end
            S_EX0: begin
                if (op == OP_STORE) cw[C_MBR_ACC] = 1'b1;
                else                cw[C_MBR_MEM] = 1'b1;
            end
            S_EX1: begin
                if (op == OP_STORE) cw[C_MEM_MBR] = 1'b1;
                else                cw[C_BR_MBR]  = 1'b1;
            end
            S_EX2: begin
                case (op)
                    OP_LOAD: cw[C_ACC_BR]  = 1'b1;
                    OP_ADD:  cw[C_ACC_ADD] = 1'b1;
                    OP_SUB:  cw[C_ACC_SUB] = 1'b1;
                    OP_AND:  cw[C_ACC_AND] = 1'b1;
                    OP_OR:   cw[C_ACC_OR]  = 1'b1;
                    default: cw = '0;
                endcase
            end
            S_EXU: begin
                case (op)
                    OP_NOT:  cw[C_ACC_NOT] = 1'b1;
                    OP_SHL:  cw[C_ACC_SHL] = 1'b1;
                    OP_SHR:  cw[C_ACC_SHR] = 1'b1;
                    default: cw = '0;
                endcase
            end
            S_HALT:  cw[C_HALT] = 1'b1;
            default: cw = '0;
        endcase
        return cw;
    endfunction

    assign op_sel    = (state == S_DEC) ? bus.ir_in : op_q;
    assign state_nxt = next_state(state, bus.start, op_sel);

    // Control/halted are loaded with the value belonging to the state being entered,
    // so they remain a pure function of the state register. The JMPGEZ flag is
    // captured on the edge that enters OP2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            control <= '0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            control <= cw_for(state_nxt, op_sel, bus.acc_neg);
            halted  <= (state_nxt == S_HALT);
            if (state == S_DEC) begin
                op_q <= bus.ir_in;
            end
        end
    end

    assign bus.control = control;
    assign bus.halted  = halted;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instruction sequences and compares the
// control word cycle by cycle against hand-computed values.
module tb_control_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    control_unit_if bus ();

    control_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected sequences, starting with the state after the current F0
    logic [24:0] seq_load   [11] = '{25'h004, 25'h009, 25'h800, 25'h000, 25'h004, 25'h009,
                                     25'h020, 25'h008, 25'h040, 25'h20000, 25'h004};
    logic [24:0] seq_jmpgez [7]  = '{25'h009, 25'h800, 25'h000, 25'h004, 25'h009, 25'h002, 25'h004};
    logic [24:0] seq_jmpneg [7]  = '{25'h009, 25'h800, 25'h000, 25'h004, 25'h009, 25'h000, 25'h004};
    logic [24:0] seq_store  [9]  = '{25'h009, 25'h800, 25'h000, 25'h004, 25'h009, 25'h020,
                                     25'h400, 25'h010, 25'h004};
    logic [24:0] seq_shl    [5]  = '{25'h009, 25'h800, 25'h000, 25'h8000, 25'h004};
    logic [24:0] seq_nop    [4]  = '{25'h009, 25'h800, 25'h000, 25'h004};
    logic [24:0] seq_add    [9]  = '{25'h009, 25'h800, 25'h000, 25'h004, 25'h009, 25'h020,
                                     25'h008, 25'h040, 25'h100};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_cw(input string tag, input logic [24:0] exp);
        step();
        check_eq(tag, 32'(bus.control), 32'(exp));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.ir_in   = 8'h00;
        bus.acc_neg = 1'b0;
        step();
        step();
        check_eq("reset_control", 32'(bus.control), 32'h0);
        check_eq("reset_halted", 32'(bus.halted), 32'h0);
        bus.start = 1'b0;
        rst_n     = 1'b1;

        // Start pulse seen only during reset must not launch a fetch
        for (int i = 0; i < 3; i++) step_cw("idle_after_reset", 25'h0);

        // Launch and abort mid-F1 with an asynchronous reset
        bus.start = 1'b1;
        step_cw("f0_before_abort", 25'h004);
        bus.start = 1'b0;
        step_cw("f1_before_abort", 25'h009);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_control", 32'(bus.control), 32'h0);
        check_eq("abort_halted", 32'(bus.halted), 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step_cw("idle_hold", 25'h0);

        // LOAD: full ten-state sequence back to F0
        bus.ir_in = 8'h01;
        bus.start = 1'b1;
        step_cw("load_f0", seq_load[0]);
        bus.start = 1'b0;
        for (int i = 1; i < 11; i++) step_cw("load_seq", seq_load[i]);

        // JMPGEZ taken, then not taken
        bus.ir_in   = 8'h05;
        bus.acc_neg = 1'b0;
        foreach (seq_jmpgez[i]) step_cw("jmpgez_pos", seq_jmpgez[i]);
        bus.acc_neg = 1'b1;
        foreach (seq_jmpneg[i]) step_cw("jmpgez_neg", seq_jmpneg[i]);
        bus.acc_neg = 1'b0;

        // STORE (9 cycles F0-to-F0), with start held high to show it is ignored
        bus.ir_in = 8'h02;
        bus.start = 1'b1;
        foreach (seq_store[i]) step_cw("store_seq", seq_store[i]);
        bus.start = 1'b0;

        bus.ir_in = 8'h0B;
        foreach (seq_shl[i]) step_cw("shl_seq", seq_shl[i]);

        bus.ir_in = 8'hFF;
        foreach (seq_nop[i]) step_cw("nop_seq", seq_nop[i]);

        // ADD with opcode input changing to HALT during OP1
        bus.ir_in = 8'h03;
        for (int i = 0; i < 4; i++) step_cw("add_seq", seq_add[i]);
        bus.ir_in = 8'h07;
        for (int i = 4; i < 9; i++) step_cw("add_seq", seq_add[i]);
        check_eq("add_not_halted", 32'(bus.halted), 32'h0);
        step_cw("add_back_f0", 25'h004);

        // HALT: sticky while start toggles, cleared only by reset
        for (int i = 0; i < 3; i++) step_cw("halt_fetch", seq_nop[i]);
        step_cw("halt_enter", 25'h40000);
        check_eq("halt_flag", 32'(bus.halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            bus.start = ~bus.start;
            step_cw("halt_hold", 25'h40000);
            check_eq("halt_flag_hold", 32'(bus.halted), 32'h1);
        end
        bus.start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("halt_reset_control", 32'(bus.control), 32'h0);
        check_eq("halt_reset_halted", 32'(bus.halted), 32'h0);
        step();
        rst_n = 1'b1;
        step_cw("idle_after_halt", 25'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
